vend_mech_arbiter: RTL and testbench
====================================

Name: vend_mech_arbiter

Overview:
- Shares one physical product-dispense motor and one change hopper between N_CH vending-machine cores.
- Each core's dispense and change pulses are queued per channel.
- Grants go round-robin to one mechanism at a time, with a start/done handshake and a post-operation cooldown.
- Sits between the Vending_Machine instances and the mechanism drivers.

Parameters:
- N_CH, 4, number of vending-machine cores (2..8).
- CNT_W, 2, width of per-channel pending counter; saturates at 2^CNT_W-1.
- COOL_CYC, 4, idle cycles enforced after each motor_done/hopper_done before the next grant (0 = none).
- TO_CYC, 64, cycles to wait for done before timeout (only with MECH_TIMEOUT_EN).

Ports:
- clk  in  1  system clock; all logic on rising edge.
- rst  in  1  synchronous, active-high reset.
- disp_req  in  N_CH  one-cycle dispense pulse per core (from each core's dispense output).
- chg_req  in  N_CH  one-cycle change pulse per core (from each core's change output).
- motor_start  out  1  one-cycle pulse starting the dispense motor.
- motor_sel  out  $clog2(N_CH)  channel being served; held stable from start until done.
- motor_done  in  1  one-cycle completion pulse from the motor driver.
- hopper_start  out  1  one-cycle pulse starting the change hopper.
- hopper_sel  out  $clog2(N_CH)  channel being served by the hopper.
- hopper_done  in  1  one-cycle completion pulse from the hopper driver.
- motor_busy  out  1  high from the start cycle through the end of cooldown.
- hopper_busy  out  1  same, for the hopper.
- ovf  out  N_CH  sticky per channel: a request arrived while its counter was saturated.
- fault  out  2  sticky; [0] motor timeout, [1] hopper timeout (0 without MECH_TIMEOUT_EN).

Behaviour:
- Reset: all counters 0; RR pointers 0; FSMs IDLE; all outputs 0. Reset mid-operation abandons the operation; no start is re-issued.
- The motor and the hopper are independent and may run concurrently. Each has its own pending counters, RR pointer and FSM.
- Pending counter per channel:
  - +1 on req.
  - -1 on the cycle its start pulse is issued.
  - Both in the same cycle: count unchanged.
  - req while saturated and not granted: count held, ovf[ch] set.
- FSM states: IDLE, WAIT_DONE, COOL, and TIMEOUT (feature only).
  - IDLE: if any counter is non-zero, pick the first non-zero channel searching upward from ptr with wrap. Registered next cycle: start=1 for exactly one cycle, sel=that channel, busy=1, ptr=channel+1 mod N_CH, state→WAIT_DONE.
  - Grant latency: a req on cycle t to an idle mechanism with empty counters gives start on cycle t+1.
  - WAIT_DONE: sel held. On done → COOL, or → IDLE if COOL_CYC=0.
  - A done pulse while IDLE or COOL is ignored.
  - COOL: counts COOL_CYC cycles, then → IDLE with busy=0. The earliest next start is the cycle after IDLE is entered.
- Fairness: no channel is granted twice while another channel has a non-zero count in between.
- Sel outputs retain the last value when idle.

Optional Feature:
- MECH_TIMEOUT_EN
- Defined: WAIT_DONE counts cycles. Reaching TO_CYC without done → set fault bit, → COOL (mechanism released). The served request is lost and not re-queued.
- Undefined: WAIT_DONE waits forever; fault tied to 0; TO_CYC unused.

Decomposition:
- Package vend_pkg:
  - FSM state enum (IDLE, WAIT_DONE, COOL, TIMEOUT).
  - Money codes (2'b00 none, 2'b01 nickel, 2'b10 dime).
  - SEL_W function/constant for $clog2(N_CH).
- Sub-module mech_sched: one pending-counter bank, RR pointer and FSM for one mechanism. Instantiated twice (motor, hopper); top is wiring plus ovf/fault aggregation.

Test Plan:
- Reset with reqs asserted → all outputs 0, no start for 3 cycles after rst deasserts if reqs are held low.
- disp_req[2] pulse at t, motor_done at t+5, COOL_CYC=4 → motor_start at t+1, motor_sel=2, motor_busy low at t+10.
- disp_req=4'b1111 in one cycle, done 3 cycles after each start → grant order 0,1,2,3, each start ≥ 5 cycles after the previous done.
- disp_req[1] ×4 pulses while busy (CNT_W=2) → ovf[1]=1, exactly 3 grants to channel 1.
- chg_req[3] and disp_req[0] on the same cycle → hopper_start and motor_start both at the next cycle, sel 3 and 0.
- MECH_TIMEOUT_EN, TO_CYC=64, no motor_done → fault[0]=1 at start+64, next pending channel granted after COOL.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared definitions for the vending-machine mechanism arbiter.
// Provides the scheduler state encodings, money codes, the select-width
// helper and a modular channel-index helper for the round-robin scan.
package vend_pkg;

    // Scheduler FSM states (ST_TIMEOUT is reserved for the timeout build)
    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_WAIT_DONE = 2'd1;
    localparam logic [1:0] ST_COOL      = 2'd2;
    localparam logic [1:0] ST_TIMEOUT   = 2'd3;

    // Coin codes used by the vending-machine cores
    typedef enum logic [1:0] {
        MONEY_NONE   = 2'b00,
        MONEY_NICKEL = 2'b01,
        MONEY_DIME   = 2'b10
    } money_e;

    // Width of a channel select for n channels
    function automatic int unsigned sel_w(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // (base + off) mod n, used to scan channels upward from the RR pointer
    function automatic int unsigned wrap_idx(input int unsigned base,
                                             input int unsigned off,
                                             input int unsigned n);
        return (base + off) % n;
    endfunction

endpackage

// File: rtl/mech_sched.sv
// One mechanism scheduler: per-channel pending counters, round-robin
// pointer and start/done/cooldown FSM.
// Optional build macro: MECH_TIMEOUT_EN (WAIT_DONE gives up after TO_CYC).
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   req[N_CH]       one-cycle request pulses per channel
//   done            one-cycle completion pulse from the driver
//   start           one-cycle start pulse (registered)
//   sel             channel being served, held until the next grant
//   busy            high from start through the end of cooldown
//   ovf_set_c       request arrived at a saturated, ungranted counter
//   fault           sticky timeout flag (0 without MECH_TIMEOUT_EN)
module mech_sched
    import vend_pkg::*;
#(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned CNT_W    = 2,
    parameter int unsigned COOL_CYC = 4,
    parameter int unsigned TO_CYC   = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CH-1:0]           req,
    input  logic                      done,
    output logic                      start,
    output logic [sel_w(N_CH)-1:0]    sel,
    output logic                      busy,
    output logic [N_CH-1:0]           ovf_set_c,
    output logic                      fault
);
    localparam int unsigned SW = sel_w(N_CH);
    localparam int unsigned CW = (COOL_CYC > 1) ? $clog2(COOL_CYC) : 1;
    localparam logic [CW-1:0]    COOL_LOAD = CW'((COOL_CYC > 0) ? COOL_CYC - 1 : 0);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [1:0]                  state_q, state_d;
    logic [N_CH-1:0][CNT_W-1:0]  cnt_q, cnt_d;
    logic [SW-1:0]               ptr_q, ptr_d;
    logic [SW-1:0]               sel_q, sel_d;
    logic                        start_q, start_d;
    logic                        busy_q, busy_d;
    logic [CW-1:0]               cool_q, cool_d;

    logic [N_CH-1:0]             pend;
    logic [SW-1:0]               scan_idx;
    logic                        gnt_vld;
    logic [SW-1:0]               gnt_ch;

`ifdef MECH_TIMEOUT_EN
    localparam int unsigned TW = (TO_CYC > 1) ? $clog2(TO_CYC) : 1;
    localparam logic [TW-1:0] TO_LAST = TW'((TO_CYC > 0) ? TO_CYC - 1 : 0);
    logic [TW-1:0] to_q, to_d;
    logic          fault_q, fault_d;
`endif

    // Round-robin pick; a same-cycle request counts so an idle mechanism grants next cycle
    always_comb begin
        pend     = '0;
        scan_idx = '0;
        gnt_vld  = 1'b0;
        gnt_ch   = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            pend[i] = req[i] | (cnt_q[i] != '0);
        end
        if (state_q == ST_IDLE) begin
            for (int unsigned k = 0; k < N_CH; k++) begin
                scan_idx = SW'(wrap_idx(int'(ptr_q), k, N_CH));
                if (!gnt_vld && pend[scan_idx]) begin
                    gnt_vld = 1'b1;
                    gnt_ch  = scan_idx;
                end
            end
        end
    end

    // Pending counters: +1 on request, -1 on grant, saturate and flag overflow
    always_comb begin
        cnt_d     = cnt_q;
        ovf_set_c = '0;
        for (int unsigned i = 0; i < N_CH; i++) begin
            if (req[i] && !(gnt_vld && gnt_ch == SW'(i))) begin
                if (cnt_q[i] == CNT_MAX) begin
                    ovf_set_c[i] = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end else if (!req[i] && gnt_vld && gnt_ch == SW'(i)) begin
                cnt_d[i] = cnt_q[i] - 1'b1;
            end
        end
    end

    // Mechanism FSM: grant, wait for done (or timeout), then cool down
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        sel_d   = sel_q;
        start_d = 1'b0;
        busy_d  = busy_q;
        cool_d  = cool_q;
`ifdef MECH_TIMEOUT_EN
        to_d    = to_q;
        fault_d = fault_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (gnt_vld) begin
                    start_d = 1'b1;
                    sel_d   = gnt_ch;
                    busy_d  = 1'b1;
                    ptr_d   = (gnt_ch == SW'(N_CH - 1)) ? '0 : gnt_ch + 1'b1;
                    state_d = ST_WAIT_DONE;
`ifdef MECH_TIMEOUT_EN
                    to_d    = '0;
`endif
                end
            end
            ST_WAIT_DONE: begin
`ifdef MECH_TIMEOUT_EN
                if (!done && to_q == TO_LAST) begin
                    fault_d = 1'b1;
                end else begin
                    to_d = to_q + 1'b1;
                end
                if (done || to_q == TO_LAST) begin
`else
                if (done) begin
`endif
                    if (COOL_CYC == 0) begin
                        state_d = ST_IDLE;
                        busy_d  = 1'b0;
                    end else begin
                        state_d = ST_COOL;
                        cool_d  = COOL_LOAD;
                    end
                end
            end
            ST_COOL: begin
                if (cool_q == '0) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                end else begin
                    cool_d = cool_q - 1'b1;
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            ptr_q   <= '0;
            sel_q   <= '0;
            start_q <= 1'b0;
            busy_q  <= 1'b0;
            cool_q  <= '0;
`ifdef MECH_TIMEOUT_EN
            to_q    <= '0;
            fault_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ptr_q   <= ptr_d;
            sel_q   <= sel_d;
            start_q <= start_d;
            busy_q  <= busy_d;
            cool_q  <= cool_d;
`ifdef MECH_TIMEOUT_EN
            to_q    <= to_d;
            fault_q <= fault_d;
`endif
        end
    end

    assign start = start_q;
    assign sel   = sel_q;
    assign busy  = busy_q;
`ifdef MECH_TIMEOUT_EN
    assign fault = fault_q;
`else
    assign fault = 1'b0;
`endif

endmodule

// File: rtl/vend_mech_arbiter.sv
// Shares one dispense motor and one change hopper between N_CH vending cores.
// Each mechanism has an independent round-robin scheduler (mech_sched).
// Optional build macro: MECH_TIMEOUT_EN (done timeout sets fault bits).
// Ports:
//   clk, rst                       clock, synchronous active-high reset
//   disp_req, chg_req [N_CH]       per-core dispense / change pulses
//   motor_start/sel/done/busy      dispense motor handshake
//   hopper_start/sel/done/busy     change hopper handshake
//   ovf [N_CH]                     sticky: request hit a saturated counter
//   fault [1:0]                    sticky timeouts: [0] motor, [1] hopper
module vend_mech_arbiter
    import vend_pkg::*;
#(
    parameter int unsigned N_CH     = 4,
    parameter int unsigned CNT_W    = 2,
    parameter int unsigned COOL_CYC = 4,
    parameter int unsigned TO_CYC   = 64
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_CH-1:0]           disp_req,
    input  logic [N_CH-1:0]           chg_req,
    output logic                      motor_start,
    output logic [$clog2(N_CH)-1:0]   motor_sel,
    input  logic                      motor_done,
    output logic                      hopper_start,
    output logic [$clog2(N_CH)-1:0]   hopper_sel,
    input  logic                      hopper_done,
    output logic                      motor_busy,
    output logic                      hopper_busy,
    output logic [N_CH-1:0]           ovf,
    output logic [1:0]                fault
);
    logic [N_CH-1:0] m_ovf_set, h_ovf_set;
    logic            m_fault, h_fault;
    logic [N_CH-1:0] ovf_q, ovf_d;

    mech_sched #(
        .N_CH(N_CH), .CNT_W(CNT_W), .COOL_CYC(COOL_CYC), .TO_CYC(TO_CYC)
    ) u_motor (
        .clk(clk), .rst(rst), .req(disp_req), .done(motor_done),
        .start(motor_start), .sel(motor_sel), .busy(motor_busy),
        .ovf_set_c(m_ovf_set), .fault(m_fault)
    );

    mech_sched #(
        .N_CH(N_CH), .CNT_W(CNT_W), .COOL_CYC(COOL_CYC), .TO_CYC(TO_CYC)
    ) u_hopper (
        .clk(clk), .rst(rst), .req(chg_req), .done(hopper_done),
        .start(hopper_start), .sel(hopper_sel), .busy(hopper_busy),
        .ovf_set_c(h_ovf_set), .fault(h_fault)
    );

    // Sticky overflow, either mechanism's counter
    always_comb begin
        ovf_d = ovf_q | m_ovf_set | h_ovf_set;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= '0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign ovf   = ovf_q;
    assign fault = {h_fault, m_fault};

endmodule

// File: tb/tb_vend_mech_arbiter.sv
module tb_vend_mech_arbiter;
    localparam int N    = 4;
    localparam int CMAX = 3;
    localparam int COOL = 4;
    localparam int TO   = 64;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [3:0] disp_req = '0;
    logic [3:0] chg_req  = '0;
    logic       motor_done  = 1'b0;
    logic       hopper_done = 1'b0;
    logic       motor_start, hopper_start, motor_busy, hopper_busy;
    logic [1:0] motor_sel, hopper_sel;
    logic [3:0] ovf;
    logic [1:0] fault;

    vend_mech_arbiter #(.N_CH(N), .CNT_W(2), .COOL_CYC(COOL), .TO_CYC(TO)) dut (
        .clk(clk), .rst(rst), .disp_req(disp_req), .chg_req(chg_req),
        .motor_start(motor_start), .motor_sel(motor_sel), .motor_done(motor_done),
        .hopper_start(hopper_start), .hopper_sel(hopper_sel), .hopper_done(hopper_done),
        .motor_busy(motor_busy), .hopper_busy(hopper_busy), .ovf(ovf), .fault(fault)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d expected %0d", nm, cyc, act, exp);
        end
    endtask

    // ---------------- behavioural model (index 0 = motor, 1 = hopper) -------------
    int         pend [2][N];
    int         ptr [2];
    int         idle_from [2];   // first cycle the mechanism may make a grant decision
    int         op_start [2];
    bit         in_op [2];
    bit         e_start [2];
    int         e_sel [2];
    bit         e_busy [2];
    logic [N-1:0] e_ovf [2];
    bit         e_fault [2];
    bit         model_on = 0;

    task automatic model_reset();
        for (int m = 0; m < 2; m++) begin
            for (int i = 0; i < N; i++) pend[m][i] = 0;
            ptr[m] = 0; idle_from[m] = 0; op_start[m] = 0; in_op[m] = 0;
            e_start[m] = 0; e_sel[m] = 0; e_busy[m] = 0; e_ovf[m] = '0; e_fault[m] = 0;
        end
    endtask

    task automatic model_step(input int m, input logic [N-1:0] rq, input logic dn);
        bit g;
        int gc;
        e_start[m] = 0;
        if (in_op[m] && dn) begin
            in_op[m] = 0;
            idle_from[m] = cyc + 1 + COOL;
        end
`ifdef MECH_TIMEOUT_EN
        else if (in_op[m] && (cyc - op_start[m]) == TO - 1) begin
            in_op[m] = 0;
            e_fault[m] = 1;
            idle_from[m] = cyc + 1 + COOL;
        end
`endif
        g = 0; gc = 0;
        if (!in_op[m] && cyc >= idle_from[m]) begin
            for (int k = 0; k < N; k++) begin
                int idx;
                idx = (ptr[m] + k) % N;
                if (!g && (pend[m][idx] > 0 || rq[idx])) begin g = 1; gc = idx; end
            end
        end
        for (int i = 0; i < N; i++) begin
            int net;
            net = pend[m][i] + int'(rq[i]) - ((g && gc == i) ? 1 : 0);
            if (net > CMAX) begin e_ovf[m][i] = 1'b1; net = CMAX; end
            pend[m][i] = net;
        end
        if (g) begin
            in_op[m] = 1; op_start[m] = cyc + 1;
            e_start[m] = 1; e_sel[m] = gc; ptr[m] = (gc + 1) % N;
        end
        e_busy[m] = in_op[m] || (cyc + 1 < idle_from[m]);
    endtask

    always @(posedge clk) begin
        if (rst) model_reset();
        else begin
            model_step(0, disp_req, motor_done);
            model_step(1, chg_req, hopper_done);
        end
        cyc++;
        model_on = 1;
    end

    // Per-cycle compare against the model
    always @(negedge clk) begin
        if (model_on) begin
            chk("m_start", int'(motor_start), int'(e_start[0]));
            chk("h_start", int'(hopper_start), int'(e_start[1]));
            chk("m_sel", int'(motor_sel), e_sel[0]);
            chk("h_sel", int'(hopper_sel), e_sel[1]);
            chk("m_busy", int'(motor_busy), int'(e_busy[0]));
            chk("h_busy", int'(hopper_busy), int'(e_busy[1]));
            chk("ovf", int'(ovf), int'(e_ovf[0] | e_ovf[1]));
            chk("fault", int'(fault), int'({e_fault[1], e_fault[0]}));
        end
    end

    // ---------------- done responders ----------------
    int m_cd = -1, h_cd = -1;
    int done_dly = 4;
    bit rand_mode = 0;
    bit auto_done = 1;

    always @(negedge clk) begin
        if (auto_done && motor_start)  m_cd = rand_mode ? $urandom_range(0, 7) : done_dly;
        if (auto_done && hopper_start) h_cd = rand_mode ? $urandom_range(0, 7) : done_dly;
        motor_done  = (m_cd == 0) || (rand_mode && $urandom_range(0, 19) == 0);
        hopper_done = (h_cd == 0) || (rand_mode && $urandom_range(0, 19) == 0);
        if (m_cd >= 0) m_cd--;
        if (h_cd >= 0) h_cd--;
    end

    task automatic do_reset();
        rst = 1'b1; disp_req = '0; chg_req = '0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1);
    end

    initial begin
        int starts [$];
        int scyc [$];
        int n1;
        logic [3:0] v;
        int n;

        // Reset with requests asserted
        rst = 1'b1; disp_req = '1; chg_req = '1;
        repeat (3) @(negedge clk);
        chk("rst_outputs", int'({motor_start, hopper_start, motor_busy, hopper_busy, ovf, fault}), 0);
        rst = 1'b0; disp_req = '0; chg_req = '0;
        repeat (3) begin
            @(negedge clk);
            chk("no_start_after_rst", int'(motor_start | hopper_start), 0);
        end

        // Single dispense on channel 2, done 4 cycles after start
        done_dly = 4;
        disp_req = 4'b0100;                 // cycle t
        @(negedge clk); disp_req = '0;      // t+1
        chk("t2_start", int'(motor_start), 1);
        chk("t2_sel", int'(motor_sel), 2);
        repeat (8) @(negedge clk);          // t+9
        chk("t2_busy_t9", int'(motor_busy), 1);
        @(negedge clk);                     // t+10
        chk("t2_busy_t10", int'(motor_busy), 0);

        // All four channels at once, done 3 cycles after each start
        do_reset();
        done_dly = 3;
        disp_req = 4'b1111;
        @(negedge clk); disp_req = '0;
        for (int c = 0; c < 60; c++) begin
            if (motor_start) begin starts.push_back(int'(motor_sel)); scyc.push_back(c); end
            @(negedge clk);
        end
        chk("t3_num_grants", starts.size(), 4);
        for (int k = 0; k < starts.size() && k < 4; k++) chk("t3_order", starts[k], k);
        for (int k = 1; k < scyc.size(); k++) chk("t3_spacing", scyc[k] - scyc[k-1], 9);

        // Overflow on channel 1 while the motor is busy
        do_reset();
        done_dly = 6;
        disp_req = 4'b0001;
        @(negedge clk);
        repeat (4) begin disp_req = 4'b0010; @(negedge clk); end
        disp_req = '0;
        n1 = 0;
        for (int c = 0; c < 80; c++) begin
            if (motor_start && motor_sel == 2'd1) n1++;
            @(negedge clk);
        end
        chk("t4_ovf", int'(ovf), 4'b0010);
        chk("t4_ch1_grants", n1, 3);

        // Concurrent motor and hopper
        do_reset();
        done_dly = 2;
        chg_req = 4'b1000; disp_req = 4'b0001;
        @(negedge clk); chg_req = '0; disp_req = '0;
        chk("t5_m_start", int'(motor_start), 1);
        chk("t5_h_start", int'(hopper_start), 1);
        chk("t5_m_sel", int'(motor_sel), 0);
        chk("t5_h_sel", int'(hopper_sel), 3);
        repeat (20) @(negedge clk);

        // Randomized traffic with random done latency, stray dones and rare resets
        do_reset();
        rand_mode = 1;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < 4; i++) v[i] = ($urandom_range(0, 4) == 0);
            disp_req = v;
            for (int i = 0; i < 4; i++) v[i] = ($urandom_range(0, 4) == 0);
            chg_req = v;
            rst = ($urandom_range(0, 499) == 0);
            @(negedge clk);
        end
        rst = 1'b0; disp_req = '0; chg_req = '0; rand_mode = 0;
        n = 0;
        while ((motor_busy || hopper_busy) && n < 300) begin @(negedge clk); n++; end
        chk("drain_bound", int'(n < 300), 1);

`ifdef MECH_TIMEOUT_EN
        // Motor never completes: fault after TO cycles, next channel after cooldown
        auto_done = 0;
        repeat (12) @(negedge clk);
        do_reset();
        disp_req = 4'b0001;
        @(negedge clk);                     // start cycle s
        chk("to_start", int'(motor_start), 1);
        disp_req = 4'b0010;
        @(negedge clk); disp_req = '0;      // s+1
        repeat (62) @(negedge clk);         // s+63
        chk("to_fault_pre", int'(fault), 0);
        @(negedge clk);                     // s+64
        chk("to_fault", int'(fault), 1);
        repeat (5) @(negedge clk);          // s+69
        chk("to_next_start", int'(motor_start), 1);
        chk("to_next_sel", int'(motor_sel), 1);
        auto_done = 1;
        do_reset();
        repeat (3) @(negedge clk);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
